// File: rtl/trail_pair_align.sv
// Camera/history pairing stage: issues history reads, holds camera pixels until the history word returns.
// Optional build macro TRAIL_ALIGN_FRAME_CHECK_EN enables the sticky short/long-frame detector.
module trail_pair_align #(
    parameter int H_ACTIVE     = 320,
    parameter int V_ACTIVE     = 180,
    parameter int READ_LATENCY = 2,
    parameter int FIFO_DEPTH   = 8,
    parameter int ADDR_W       = $clog2(H_ACTIVE * V_ACTIVE)
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              camera_valid_in,
    input  logic [23:0]       camera_pixel_in,
    input  logic              frame_start_in,
    output logic              hist_rd_en_out,
    output logic [ADDR_W-1:0] hist_addr_out,
    input  logic [23:0]       hist_data_in,
    output logic              pair_valid_out,
    output logic [23:0]       history_out,
    output logic [23:0]       camera_out,
    output logic [ADDR_W-1:0] addr_out,
    output logic              overflow_out,
    output logic              frame_error_out
);

    localparam int                FRAME_PIXELS = H_ACTIVE * V_ACTIVE;
    localparam logic [ADDR_W-1:0] LAST_ADDR    = ADDR_W'(FRAME_PIXELS - 1);
    localparam int                PTR_W        = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]    FULL_COUNT   = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [0:0] {
        ST_SYNC = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic                    accept_s, push_s, pop_s, ret_s;
    logic                    fifo_full_s, fifo_empty_s;
    logic [ADDR_W-1:0]       pix_addr_s;
    logic [ADDR_W-1:0]       next_addr_q, next_addr_d;
    logic [READ_LATENCY-1:0] req_sr_q;
    logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]          count_q, count_d;
    logic [23:0]             fifo_pix_q  [FIFO_DEPTH];
    logic [ADDR_W-1:0]       fifo_addr_q [FIFO_DEPTH];

    logic                    hist_rd_en_q, pair_valid_q, overflow_q;
    logic [ADDR_W-1:0]       hist_addr_q, addr_q;
    logic [23:0]             history_q, camera_q;

    // State register
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= ST_SYNC;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: leave SYNC only on a qualified frame start
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_SYNC: begin
                if (camera_valid_in && frame_start_in) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_SYNC;
                end
            end
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_SYNC;
        endcase
    end

    // FSM output: which camera pixels are accepted
    always_comb begin
        accept_s = 1'b0;
        case (state_q)
            ST_SYNC: accept_s = camera_valid_in && frame_start_in;
            ST_RUN:  accept_s = camera_valid_in;
            default: accept_s = 1'b0;
        endcase
    end

    assign fifo_full_s  = (count_q == FULL_COUNT);
    assign fifo_empty_s = (count_q == '0);
    assign push_s       = accept_s && !fifo_full_s;
    assign ret_s        = req_sr_q[READ_LATENCY-1];
    // A return with nothing queued is ignored rather than producing a bogus pair
    assign pop_s        = ret_s && !fifo_empty_s;
    assign pix_addr_s   = frame_start_in ? '0 : next_addr_q;

    // Address counter and FIFO occupancy next-state
    always_comb begin
        next_addr_d = next_addr_q;
        if (push_s) begin
            next_addr_d = (pix_addr_s == LAST_ADDR) ? '0 : pix_addr_s + ADDR_W'(1);
        end else begin
            next_addr_d = next_addr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + (PTR_W + 1)'(1);
            2'b01:   count_d = count_q - (PTR_W + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Control registers: address counter, FIFO pointers, request shift register
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            next_addr_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            req_sr_q    <= '0;
        end else begin
            next_addr_q <= next_addr_d;
            count_q     <= count_d;
            req_sr_q    <= READ_LATENCY'({req_sr_q, hist_rd_en_q});
            if (push_s) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    // FIFO storage for the camera pixel and its address
    always_ff @(posedge clk_in) begin
        if (push_s) begin
            fifo_pix_q[wr_ptr_q]  <= camera_pixel_in;
            fifo_addr_q[wr_ptr_q] <= pix_addr_s;
        end
    end

    // Output registers; pair fields hold between strobes
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            hist_rd_en_q <= 1'b0;
            hist_addr_q  <= '0;
            pair_valid_q <= 1'b0;
            history_q    <= '0;
            camera_q     <= '0;
            addr_q       <= '0;
            overflow_q   <= 1'b0;
        end else begin
            hist_rd_en_q <= push_s;
            pair_valid_q <= pop_s;
            if (push_s) begin
                hist_addr_q <= pix_addr_s;
            end
            if (pop_s) begin
                history_q <= hist_data_in;
                camera_q  <= fifo_pix_q[rd_ptr_q];
                addr_q    <= fifo_addr_q[rd_ptr_q];
            end
            if (accept_s && fifo_full_s) begin
                overflow_q <= 1'b1;
            end
        end
    end

`ifdef TRAIL_ALIGN_FRAME_CHECK_EN
    logic frame_err_set_s;
    logic frame_err_q;

    // Short frame: restart before the counter came back to 0; long frame: wrap without a start
    always_comb begin
        frame_err_set_s = 1'b0;
        if (push_s && (state_q == ST_RUN)) begin
            frame_err_set_s = frame_start_in ? (next_addr_q != '0) : (next_addr_q == '0);
        end else begin
            frame_err_set_s = 1'b0;
        end
    end

    // Sticky frame error flag
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            frame_err_q <= 1'b0;
        end else if (frame_err_set_s) begin
            frame_err_q <= 1'b1;
        end
    end

    assign frame_error_out = frame_err_q;
`else
    assign frame_error_out = 1'b0;
`endif

    assign hist_rd_en_out = hist_rd_en_q;
    assign hist_addr_out  = hist_addr_q;
    assign pair_valid_out = pair_valid_q;
    assign history_out    = history_q;
    assign camera_out     = camera_q;
    assign addr_out       = addr_q;
    assign overflow_out   = overflow_q;

endmodule

// File: tb/tb_trail_pair_align.sv
// Bench for trail_pair_align: small 4x2 frame, 2-cycle history memory model returning 0x010203+addr.
module tb_trail_pair_align;

    localparam int H = 4, V = 2, RL = 2, DEPTH = 8, AW = 3, NPIX = H * V;
`ifdef TRAIL_ALIGN_FRAME_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b0;
    logic          camera_valid_in = 1'b0;
    logic [23:0]   camera_pixel_in = 24'd0;
    logic          frame_start_in = 1'b0;
    logic          hist_rd_en_out;
    logic [AW-1:0] hist_addr_out;
    logic [23:0]   hist_data_in;
    logic          pair_valid_out;
    logic [23:0]   history_out, camera_out;
    logic [AW-1:0] addr_out;
    logic          overflow_out, frame_error_out;

    trail_pair_align #(
        .H_ACTIVE(H), .V_ACTIVE(V), .READ_LATENCY(RL), .FIFO_DEPTH(DEPTH), .ADDR_W(AW)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .camera_valid_in(camera_valid_in), .camera_pixel_in(camera_pixel_in),
        .frame_start_in(frame_start_in),
        .hist_rd_en_out(hist_rd_en_out), .hist_addr_out(hist_addr_out),
        .hist_data_in(hist_data_in),
        .pair_valid_out(pair_valid_out), .history_out(history_out),
        .camera_out(camera_out), .addr_out(addr_out),
        .overflow_out(overflow_out), .frame_error_out(frame_error_out)
    );

    always #5 clk_in = ~clk_in;

    // History memory: data valid RL cycles after the request, content = 0x010203 + address
    logic          m1_v, m2_v;
    logic [AW-1:0] m1_a, m2_a;
    always @(posedge clk_in) begin
        m1_v <= hist_rd_en_out;
        m1_a <= hist_addr_out;
        m2_v <= m1_v;
        m2_a <= m1_a;
    end
    assign hist_data_in = m2_v ? (24'h010203 + {21'd0, m2_a}) : 24'h5A5A5A;

    int vectors = 0, errors = 0, cyc = 0;
    bit chk_en = 1'b0;
    bit m_run = 1'b0, m_err = 1'b0;
    int m_next = 0;
    logic [23:0] last_h = 24'd0, last_c = 24'd0;
    logic [AW-1:0] last_a = '0;
    logic [AW-1:0] exp_rd [int];
    logic [23:0]   exp_ph [int];
    logic [23:0]   exp_pc [int];
    logic [AW-1:0] exp_pa [int];
    int pairs_seen = 0, pairs_expected = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // One clock: check this cycle's outputs against the model, then drive and model this cycle's inputs
    task automatic cycle(input bit v, input bit fs, input logic [23:0] pix, input bit rst);
        int a;
        @(negedge clk_in);
        if (chk_en) begin
            if (pair_valid_out) pairs_seen++;
            if (exp_ph.exists(cyc)) begin
                last_h = exp_ph[cyc];
                last_c = exp_pc[cyc];
                last_a = exp_pa[cyc];
            end
            chk("rd_en", hist_rd_en_out, exp_rd.exists(cyc));
            if (exp_rd.exists(cyc)) chk("rd_addr", hist_addr_out, exp_rd[cyc]);
            chk("pair_valid", pair_valid_out, exp_ph.exists(cyc));
            chk("history", history_out, last_h);
            chk("camera", camera_out, last_c);
            chk("addr", addr_out, last_a);
            chk("overflow", overflow_out, 0);
            chk("frame_error", frame_error_out, m_err & CHECK_EN);
        end
        camera_valid_in = v;
        frame_start_in  = fs;
        camera_pixel_in = pix;
        rst_in          = rst;
        if (rst) begin
            m_run = 1'b0; m_next = 0; m_err = 1'b0;
            last_h = 24'd0; last_c = 24'd0; last_a = '0;
            for (int k = 1; k <= RL + 2; k++) begin
                if (exp_rd.exists(cyc + k)) exp_rd.delete(cyc + k);
                if (exp_ph.exists(cyc + k)) begin
                    exp_ph.delete(cyc + k);
                    pairs_expected--;
                end
            end
        end else if (v && (m_run || fs)) begin
            a = fs ? 0 : m_next;
            if (m_run && ((fs && m_next != 0) || (!fs && m_next == 0))) m_err = 1'b1;
            m_run  = 1'b1;
            m_next = (a + 1) % NPIX;
            exp_rd[cyc + 1]      = AW'(a);
            exp_ph[cyc + 2 + RL] = 24'h010203 + 24'(a);
            exp_pc[cyc + 2 + RL] = pix;
            exp_pa[cyc + 2 + RL] = AW'(a);
            pairs_expected++;
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 24'd0, 1'b0);
    endtask

    typedef struct {
        bit v; bit fs; logic [23:0] pix;
        bit e_rd; logic [AW-1:0] e_ra;
        bit e_pv; logic [23:0] e_h; logic [23:0] e_c; logic [AW-1:0] e_a;
    } vec_t;
    vec_t tbl [9];

    initial begin
        int base;
        bit rv, rfs, rrst;
        tbl[0] = '{1, 1, 24'hAA0000, 0, 3'd0, 0, 24'h0, 24'h0, 3'd0};
        tbl[1] = '{1, 0, 24'hAA0001, 1, 3'd0, 0, 24'h0, 24'h0, 3'd0};
        tbl[2] = '{1, 0, 24'hAA0002, 1, 3'd1, 0, 24'h0, 24'h0, 3'd0};
        tbl[3] = '{1, 0, 24'hAA0003, 1, 3'd2, 0, 24'h0, 24'h0, 3'd0};
        tbl[4] = '{0, 0, 24'h000000, 1, 3'd3, 1, 24'h010203, 24'hAA0000, 3'd0};
        tbl[5] = '{0, 0, 24'h000000, 0, 3'd0, 1, 24'h010204, 24'hAA0001, 3'd1};
        tbl[6] = '{0, 0, 24'h000000, 0, 3'd0, 1, 24'h010205, 24'hAA0002, 3'd2};
        tbl[7] = '{0, 0, 24'h000000, 0, 3'd0, 1, 24'h010206, 24'hAA0003, 3'd3};
        tbl[8] = '{0, 0, 24'h000000, 0, 3'd0, 0, 24'h0, 24'h0, 3'd0};

        // Reset, then reset values
        cycle(1'b0, 1'b0, 24'd0, 1'b1);
        cycle(1'b0, 1'b0, 24'd0, 1'b1);
        chk_en = 1'b1;
        cycle(1'b0, 1'b0, 24'd0, 1'b0);
        chk("rst_hist_addr", hist_addr_out, 0);
        chk("rst_pair_valid", pair_valid_out, 0);

        // Pixels without a frame start are dropped in SYNC
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 24'($urandom), 1'b0);
        idle(6);

        // Table: frame start + 4 back-to-back pixels
        for (int r = 0; r < 9; r++) begin
            cycle(tbl[r].v, tbl[r].fs, tbl[r].pix, 1'b0);
            chk("tbl_rd_en", hist_rd_en_out, tbl[r].e_rd);
            if (tbl[r].e_rd) chk("tbl_rd_addr", hist_addr_out, tbl[r].e_ra);
            chk("tbl_pair_valid", pair_valid_out, tbl[r].e_pv);
            if (tbl[r].e_pv) begin
                chk("tbl_history", history_out, tbl[r].e_h);
                chk("tbl_camera", camera_out, tbl[r].e_c);
                chk("tbl_addr", addr_out, tbl[r].e_a);
            end
        end

        // Full 8-pixel frame then a new frame start: clean
        cycle(1'b0, 1'b0, 24'd0, 1'b1);
        for (int i = 0; i < NPIX; i++) cycle(1'b1, i == 0, 24'hBB0000 + 24'(i), 1'b0);
        cycle(1'b1, 1'b1, 24'hBB0100, 1'b0);
        idle(6);
        chk("full_frame_err", frame_error_out, 0);

        // Short frame: restart after address 5
        for (int i = 1; i <= 5; i++) cycle(1'b1, 1'b0, 24'hCC0000 + 24'(i), 1'b0);
        cycle(1'b1, 1'b1, 24'hCC0100, 1'b0);
        idle(2);
        chk("short_frame_err", frame_error_out, CHECK_EN);
        idle(4);
        chk("short_frame_sticky", frame_error_out, CHECK_EN);

        // Long frame: 9th pixel wraps to 0 without a frame start
        cycle(1'b0, 1'b0, 24'd0, 1'b1);
        for (int i = 0; i < NPIX + 1; i++) cycle(1'b1, i == 0, 24'hDD0000 + 24'(i), 1'b0);
        idle(6);
        chk("long_frame_err", frame_error_out, CHECK_EN);

        // Reset while three reads are in flight
        cycle(1'b0, 1'b0, 24'd0, 1'b1);
        idle(2);
        base = pairs_seen;
        cycle(1'b1, 1'b1, 24'hEE0000, 1'b0);
        cycle(1'b1, 1'b0, 24'hEE0001, 1'b0);
        cycle(1'b1, 1'b0, 24'hEE0002, 1'b0);
        cycle(1'b0, 1'b0, 24'd0, 1'b1);
        cycle(1'b0, 1'b0, 24'd0, 1'b0);
        chk("post_rst_rd_en", hist_rd_en_out, 0);
        chk("post_rst_hist_addr", hist_addr_out, 0);
        chk("post_rst_camera", camera_out, 0);
        idle(10);
        chk("no_pairs_after_rst", pairs_seen - base, 0);

        // Sparse stream: one pixel every third cycle
        base = pairs_seen;
        for (int i = 0; i < 50; i++) begin
            cycle(1'b1, i == 0, 24'($urandom), 1'b0);
            idle(2);
        end
        idle(8);
        chk("sparse_pair_count", pairs_seen - base, 50);
        chk("sparse_overflow", overflow_out, 0);

        // Random traffic with occasional frame starts and resets
        for (int i = 0; i < 400; i++) begin
            rv   = ($urandom_range(0, 3) != 0);
            rfs  = ($urandom_range(0, 9) == 0);
            rrst = ($urandom_range(0, 80) == 0);
            cycle(rv, rfs, 24'($urandom), rrst);
        end
        idle(10);
        chk("pairs_total", pairs_seen, pairs_expected);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
